// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, NOP encoding, fetch FSM states and default widths.
package cpu_pkg;

  localparam int unsigned PC_WIDTH_DEF    = 8;
  localparam int unsigned INSTR_WIDTH_DEF = 20;

  localparam logic [3:0] OPCODE_NOP    = 4'b0000;
  localparam logic [3:0] OPCODE_ADD    = 4'b0001;
  localparam logic [3:0] OPCODE_SUB    = 4'b0010;
  localparam logic [3:0] OPCODE_AND    = 4'b0011;
  localparam logic [3:0] OPCODE_OR     = 4'b0100;
  localparam logic [3:0] OPCODE_XOR    = 4'b0101;
  localparam logic [3:0] OPCODE_ADDI   = 4'b0110;
  localparam logic [3:0] OPCODE_BEQ    = 4'b1000;
  localparam logic [3:0] OPCODE_BNE    = 4'b1001;
  localparam logic [3:0] OPCODE_JMP    = 4'b1010;
  localparam logic [3:0] OPCODE_LOAD   = 4'b1011;
  localparam logic [3:0] OPCODE_STORE  = 4'b1100;

  localparam logic [INSTR_WIDTH_DEF-1:0] NOP = 20'h00000;

  typedef enum logic {
    REQ  = 1'b0,
    RESP = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/response bus between the fetch stage and imem.
interface instruction_fetch_if #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 20
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ready;
  logic                   imem_rvalid;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/if_skid_buffer.sv
// One-entry {instr, pc} store catching a response that lands while decode stalls.
module if_skid_buffer #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 20
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   drain,
  input  logic                   clear,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [PC_WIDTH-1:0]    pc_in,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   full
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full  <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear) begin
      full  <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= instr_in;
      pc    <= pc_in;
    end else if (drain) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one imem request at a time and fills the IF/ID register.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned         PC_WIDTH    = PC_WIDTH_DEF,
  parameter int unsigned         INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  instruction_fetch_if.master      imem,
  input  logic                     stall,
  input  logic                     branch_taken,
  input  logic [PC_WIDTH-1:0]      branch_target,
  output logic [INSTR_WIDTH-1:0]   instr_out,
  output logic [PC_WIDTH-1:0]      pc_out,
  output logic                     instr_valid
);

  localparam logic [INSTR_WIDTH-1:0] NOP_W = INSTR_WIDTH'(NOP);

  fetch_state_t            state, state_next;
  logic [PC_WIDTH-1:0]     pc, pc_next;
  logic [PC_WIDTH-1:0]     req_pc, req_pc_next;
  logic                    discard, discard_next;
  logic [INSTR_WIDTH-1:0]  instr_next;
  logic [PC_WIDTH-1:0]     pc_out_next;
  logic                    valid_next;

  logic                    skid_load, skid_drain, skid_clear, skid_full;
  logic [INSTR_WIDTH-1:0]  skid_instr;
  logic [PC_WIDTH-1:0]     skid_pc;

  logic accept, resp, resp_ok;

  // Gated by reset so no request is presented while reset is held low.
  assign imem.imem_req  = reset && (state == REQ) && !skid_full;
  assign imem.imem_addr = pc;

  assign accept  = imem.imem_req && imem.imem_ready;
  assign resp    = (state == RESP) && imem.imem_rvalid;
  assign resp_ok = resp && !discard;

  if_skid_buffer #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_skid (
    .clock    (clock),
    .reset    (reset),
    .load     (skid_load),
    .drain    (skid_drain),
    .clear    (skid_clear),
    .instr_in (imem.imem_rdata),
    .pc_in    (req_pc),
    .instr    (skid_instr),
    .pc       (skid_pc),
    .full     (skid_full)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= REQ;
      pc          <= RESET_PC;
      req_pc      <= '0;
      discard     <= 1'b0;
      instr_out   <= NOP_W;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      req_pc      <= req_pc_next;
      discard     <= discard_next;
      instr_out   <= instr_next;
      pc_out      <= pc_out_next;
      instr_valid <= valid_next;
    end
  end

  // Flush keeps the FSM in RESP with discard set while a request is still in flight.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    req_pc_next  = req_pc;
    discard_next = discard;
    if (branch_taken) begin
      pc_next = branch_target;
      if (accept) req_pc_next = pc;
      if (accept || (state == RESP && !imem.imem_rvalid)) begin
        state_next   = RESP;
        discard_next = 1'b1;
      end else begin
        state_next   = REQ;
        discard_next = 1'b0;
      end
    end else begin
      unique case (state)
        REQ: begin
          if (accept) begin
            req_pc_next = pc;
            pc_next     = pc + PC_WIDTH'(1);
            state_next  = RESP;
          end
        end
        RESP: begin
          if (imem.imem_rvalid) begin
            state_next   = REQ;
            discard_next = 1'b0;
          end
        end
        default: state_next = REQ;
      endcase
    end
  end

  always_comb begin
    instr_next  = instr_out;
    pc_out_next = pc_out;
    valid_next  = instr_valid;
    skid_load   = 1'b0;
    skid_drain  = 1'b0;
    skid_clear  = 1'b0;
    if (branch_taken) begin
      instr_next = NOP_W;
      valid_next = 1'b0;
      skid_clear = 1'b1;
    end else if (skid_full) begin
      if (!stall) begin
        instr_next  = skid_instr;
        pc_out_next = skid_pc;
        valid_next  = 1'b1;
        skid_drain  = 1'b1;
      end
    end else if (resp_ok) begin
      if (!stall || !instr_valid) begin
        instr_next  = imem.imem_rdata;
        pc_out_next = req_pc;
        valid_next  = 1'b1;
      end else begin
        skid_load = 1'b1;
      end
    end else if (!stall) begin
      instr_next = NOP_W;
      valid_next = 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural instruction memory of programmable latency.
module tb_instruction_fetch;

  logic       clock = 1'b0;
  logic       reset;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic [19:0] instr_out;
  logic [7:0]  pc_out;
  logic        instr_valid;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned mem_lat = 1;

  instruction_fetch_if #(.PC_WIDTH(8), .INSTR_WIDTH(20)) bus ();

  instruction_fetch #(.PC_WIDTH(8), .INSTR_WIDTH(20), .RESET_PC(8'h00)) dut (
    .clock         (clock),
    .reset         (reset),
    .imem          (bus.master),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid)
  );

  always #5 clock = ~clock;

  logic [28:0] ifid;
  logic [8:0]  reqv;
  assign ifid = {instr_valid, instr_out, pc_out};
  assign reqv = {bus.imem_req, bus.imem_addr};

  function automatic logic [19:0] mem_word(input logic [7:0] a);
    case (a)
      8'h00:   return 20'hA1234;
      8'h01:   return 20'hC5670;
      default: return {4'h3, a, a};
    endcase
  endfunction

  logic       busy;
  int unsigned cnt;
  logic [7:0] paddr;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.imem_rvalid <= 1'b0;
      bus.imem_rdata  <= '0;
      busy            <= 1'b0;
      cnt             <= 0;
      paddr           <= '0;
    end else begin
      bus.imem_rvalid <= 1'b0;
      if (busy) begin
        if (cnt <= 1) begin
          bus.imem_rvalid <= 1'b1;
          bus.imem_rdata  <= mem_word(paddr);
          busy            <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (bus.imem_req && bus.imem_ready) begin
        if (mem_lat <= 1) begin
          bus.imem_rvalid <= 1'b1;
          bus.imem_rdata  <= mem_word(bus.imem_addr);
        end else begin
          busy  <= 1'b1;
          cnt   <= mem_lat - 1;
          paddr <= bus.imem_addr;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    bus.imem_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if (reqv !== 9'h000) begin n_err++; $display("FAIL reset_req: got %h want %h", reqv, 9'h000); end
    n_cmp++;
    if (ifid !== 29'h0) begin n_err++; $display("FAIL reset_ifid: got %h want %h", ifid, 29'h0); end
  endtask

  task automatic test_sequential();
    reset = 1'b1; #1;
    n_cmp++;
    if (reqv !== {1'b1, 8'h00}) begin n_err++; $display("FAIL seq_addr0: got %h want %h", reqv, {1'b1, 8'h00}); end
    tick();
    n_cmp++;
    if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL seq_resp_noreq: got %b want 0", bus.imem_req); end
    tick();
    n_cmp++;
    if (ifid !== {1'b1, 20'hA1234, 8'h00}) begin n_err++; $display("FAIL seq_instr0: got %h want %h", ifid, {1'b1, 20'hA1234, 8'h00}); end
    n_cmp++;
    if (reqv !== {1'b1, 8'h01}) begin n_err++; $display("FAIL seq_addr1: got %h want %h", reqv, {1'b1, 8'h01}); end
    tick();
    n_cmp++;
    if (instr_valid !== 1'b0) begin n_err++; $display("FAIL seq_bubble: got %b want 0", instr_valid); end
    tick();
    n_cmp++;
    if (ifid !== {1'b1, 20'hC5670, 8'h01}) begin n_err++; $display("FAIL seq_instr1: got %h want %h", ifid, {1'b1, 20'hC5670, 8'h01}); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (ifid !== {1'b1, 20'hC5670, 8'h01}) begin n_err++; $display("FAIL stall_hold%0d: got %h want %h", i, ifid, {1'b1, 20'hC5670, 8'h01}); end
      n_cmp++;
      if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL stall_noreq%0d: got %b want 0", i, bus.imem_req); end
      if (i > 0) begin
        n_cmp++;
        if (dut.u_skid.full !== 1'b1) begin n_err++; $display("FAIL stall_skid_full%0d: got %b want 1", i, dut.u_skid.full); end
      end
    end
    stall = 1'b0;
    tick();
    n_cmp++;
    if (ifid !== {1'b1, 20'h30202, 8'h02}) begin n_err++; $display("FAIL stall_drain: got %h want %h", ifid, {1'b1, 20'h30202, 8'h02}); end
    n_cmp++;
    if (reqv !== {1'b1, 8'h03}) begin n_err++; $display("FAIL stall_resume: got %h want %h", reqv, {1'b1, 8'h03}); end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (reqv !== {1'b1, 8'h05}) begin n_err++; $display("FAIL br_addr5: got %h want %h", reqv, {1'b1, 8'h05}); end
    mem_lat = 3;
    tick();
    branch_taken = 1'b1; branch_target = 8'h40;
    tick();
    branch_taken = 1'b0;
    n_cmp++;
    if ({instr_valid, bus.imem_req} !== 2'b00) begin n_err++; $display("FAIL br_flush: got %b want 00", {instr_valid, bus.imem_req}); end
    tick();
    mem_lat = 1;
    tick();
    n_cmp++;
    if (instr_valid !== 1'b0) begin n_err++; $display("FAIL br_drop5: got %b want 0", instr_valid); end
    n_cmp++;
    if (reqv !== {1'b1, 8'h40}) begin n_err++; $display("FAIL br_target: got %h want %h", reqv, {1'b1, 8'h40}); end
    tick(); tick();
    n_cmp++;
    if (ifid !== {1'b1, 20'h34040, 8'h40}) begin n_err++; $display("FAIL br_instr40: got %h want %h", ifid, {1'b1, 20'h34040, 8'h40}); end
  endtask

  task automatic test_branch_stall();
    stall = 1'b1;
    tick(); tick();
    n_cmp++;
    if (dut.u_skid.full !== 1'b1) begin n_err++; $display("FAIL bs_skid_full: got %b want 1", dut.u_skid.full); end
    branch_taken = 1'b1; branch_target = 8'h80;
    tick();
    branch_taken = 1'b0;
    n_cmp++;
    if ({ifid[28], ifid[27:8], dut.u_skid.full} !== {1'b0, 20'h00000, 1'b0}) begin
      n_err++; $display("FAIL bs_flush: got %h want %h", {ifid[28], ifid[27:8], dut.u_skid.full}, {1'b0, 20'h00000, 1'b0});
    end
    n_cmp++;
    if (reqv !== {1'b1, 8'h80}) begin n_err++; $display("FAIL bs_target: got %h want %h", reqv, {1'b1, 8'h80}); end
    stall = 1'b0;
    tick(); tick();
    n_cmp++;
    if (ifid !== {1'b1, 20'h38080, 8'h80}) begin n_err++; $display("FAIL bs_instr80: got %h want %h", ifid, {1'b1, 20'h38080, 8'h80}); end
  endtask

  task automatic test_wrap_ready();
    branch_taken = 1'b1; branch_target = 8'hFF;
    tick();
    branch_taken = 1'b0;
    tick();
    n_cmp++;
    if (instr_valid !== 1'b0) begin n_err++; $display("FAIL wr_drop81: got %b want 0", instr_valid); end
    n_cmp++;
    if (reqv !== {1'b1, 8'hFF}) begin n_err++; $display("FAIL wr_addrFF: got %h want %h", reqv, {1'b1, 8'hFF}); end
    tick(); tick();
    n_cmp++;
    if (ifid !== {1'b1, 20'h3FFFF, 8'hFF}) begin n_err++; $display("FAIL wr_instrFF: got %h want %h", ifid, {1'b1, 20'h3FFFF, 8'hFF}); end
    n_cmp++;
    if (reqv !== {1'b1, 8'h00}) begin n_err++; $display("FAIL wr_wrap: got %h want %h", reqv, {1'b1, 8'h00}); end
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (reqv !== {1'b1, 8'h00}) begin n_err++; $display("FAIL wr_notready%0d: got %h want %h", i, reqv, {1'b1, 8'h00}); end
    end
    bus.imem_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if (ifid !== {1'b1, 20'hA1234, 8'h00}) begin n_err++; $display("FAIL wr_instr0: got %h want %h", ifid, {1'b1, 20'hA1234, 8'h00}); end
  endtask

  task automatic test_reset_mid();
    tick();
    n_cmp++;
    if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rm_in_resp: got %b want 0", bus.imem_req); end
    reset = 1'b0; #1;
    n_cmp++;
    if ({reqv, ifid} !== {9'h000, 29'h0}) begin n_err++; $display("FAIL rm_async: got %h want %h", {reqv, ifid}, {9'h000, 29'h0}); end
    tick();
    reset = 1'b1; #1;
    n_cmp++;
    if (reqv !== {1'b1, 8'h00}) begin n_err++; $display("FAIL rm_reset_pc: got %h want %h", reqv, {1'b1, 8'h00}); end
    tick(); tick();
    n_cmp++;
    if (ifid !== {1'b1, 20'hA1234, 8'h00}) begin n_err++; $display("FAIL rm_refetch: got %h want %h", ifid, {1'b1, 20'hA1234, 8'h00}); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_stall();
    test_wrap_ready();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
